// File: rtl/vga_capture.sv
// vga_capture: locks onto an incoming hs/vs pixel stream, locates the active window, decimates it
// by SCALE in both axes and writes the surviving RGB332 pixels into the frame RAM write port.
// Optional build macro VGA_CAPTURE_CHECK_EN enables line/frame length checking, the err pulse and
// the one-frame ARMED qualification before lock.
module vga_capture #(
  parameter int unsigned HV_ALL    = 1648,
  parameter int unsigned HV_A      = 176,
  parameter int unsigned HV_B      = 176,
  parameter int unsigned HV_C      = 1280,
  parameter int unsigned VV_ALL    = 800,
  parameter int unsigned VV_A      = 3,
  parameter int unsigned VV_B      = 28,
  parameter int unsigned VV_C      = 768,
  parameter int unsigned SCALE     = 8,
  parameter int unsigned BASE_ADDR = 25500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic [7:0]  rgb,
  input  logic        cap_en,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_done,
  output logic        locked,
  output logic        err
);

  localparam int unsigned Cols = HV_C / SCALE;
  localparam int unsigned Rows = VV_C / SCALE;

  localparam logic [10:0] XStart  = 11'(HV_A + HV_B);
  localparam logic [10:0] XEnd    = 11'(HV_A + HV_B + HV_C);
  localparam logic [10:0] YStart  = 11'(VV_A + VV_B);
  localparam logic [10:0] YEnd    = 11'(VV_A + VV_B + VV_C);
  localparam logic [10:0] XLast   = 11'(HV_A + HV_B + (Cols - 1) * SCALE);
  localparam logic [10:0] YLast   = 11'(VV_A + VV_B + (Rows - 1) * SCALE);
  localparam logic [10:0] PhMask  = 11'(SCALE - 1);
  localparam logic [10:0] CntSat  = 11'h7ff;
  localparam logic [15:0] Base    = 16'(BASE_ADDR);
  localparam logic [15:0] RowStep = 16'(Cols);
  // A geometry whose active window does not fit inside the line/frame never produces writes.
  localparam bit CfgOk = (HV_A + HV_B + HV_C <= HV_ALL) && (VV_A + VV_B + VV_C <= VV_ALL);
`ifdef VGA_CAPTURE_CHECK_EN
  localparam logic [10:0] XMax = 11'(HV_ALL - 1);
  localparam logic [10:0] YMax = 11'(VV_ALL - 1);
`endif

  typedef enum logic [1:0] {StSeek, StArmed, StLocked, StCapture} state_e;

  logic        hs_q, hs_qq, vs_q, vs_qq, cap_q;
  logic [7:0]  rgb_q;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [15:0] col_q, col_d, row_base_q, row_base_d;
  logic        rowhit_q, rowhit_d;
  logic        line_start, frame_start, hit, last_hit, viol;

  state_e      state_q;
  logic        wr_en_q, done_pend_q, frame_done_q, locked_q, err_q;
  logic [15:0] wr_addr_q;
  logic [7:0]  wr_data_q;

  // Input stage: one register on every input, plus a second copy of the syncs for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= 1'b1;
      hs_qq <= 1'b1;
      vs_q  <= 1'b1;
      vs_qq <= 1'b1;
      cap_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= hs;
      hs_qq <= hs_q;
      vs_q  <= vs;
      vs_qq <= vs_q;
      cap_q <= cap_en;
      rgb_q <= rgb;
    end
  end

  // Position tracking and decimation decision for the pixel currently held in rgb_q.
  always_comb begin
    line_start  = hs_qq & ~hs_q;
    frame_start = vs_qq & ~vs_q;

    x_d = line_start ? '0 : ((x_q == CntSat) ? CntSat : 11'(x_q + 11'd1));
    y_d = y_q;
    if (frame_start) begin
      y_d = '0;
    end else if (line_start) begin
      y_d = (y_q == CntSat) ? CntSat : 11'(y_q + 11'd1);
    end

    hit = CfgOk && (x_d >= XStart) && (x_d < XEnd) && (y_d >= YStart) && (y_d < YEnd) &&
          (((x_d - XStart) & PhMask) == '0) && (((y_d - YStart) & PhMask) == '0);
    last_hit = hit && (x_d == XLast) && (y_d == YLast);

    col_d = line_start ? '0 : (hit ? 16'(col_q + 16'd1) : col_q);

    // The row base advances at the start of the line following a sampled row.
    row_base_d = row_base_q;
    if (frame_start) begin
      row_base_d = Base;
    end else if (line_start && rowhit_q) begin
      row_base_d = 16'(row_base_q + RowStep);
    end
    rowhit_d = (frame_start || line_start) ? 1'b0 : (rowhit_q | hit);

    viol = 1'b0;
`ifdef VGA_CAPTURE_CHECK_EN
    // Too short: a line/frame start arrives early. Too long: the last position passes without one.
    if (line_start ? (x_q != XMax) : (x_q == XMax)) begin
      viol = 1'b1;
    end
    if (frame_start ? (y_q != YMax) : (line_start && (y_q == YMax))) begin
      viol = 1'b1;
    end
`endif
  end

  // Position and address counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
      row_base_q <= Base;
      rowhit_q   <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      rowhit_q   <= rowhit_d;
    end
  end

  // Lock/capture FSM with registered write port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StSeek;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= Base;
      wr_data_q    <= '0;
      done_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      err_q        <= 1'b0;
      done_pend_q  <= 1'b0;
      frame_done_q <= done_pend_q;
      if (viol && (state_q != StSeek)) begin
        state_q      <= StSeek;
        locked_q     <= 1'b0;
        err_q        <= 1'b1;
        frame_done_q <= 1'b0;
      end else begin
        case (state_q)
          StSeek: begin
            if (frame_start) begin
`ifdef VGA_CAPTURE_CHECK_EN
              state_q  <= StArmed;
`else
              state_q  <= StLocked;
              locked_q <= 1'b1;
`endif
            end
          end
          StArmed: begin
            // Reaching a frame start here means the whole observed frame was clean.
            if (frame_start) begin
              state_q  <= StLocked;
              locked_q <= 1'b1;
            end
          end
          StLocked: begin
            if (frame_start && cap_q) begin
              state_q <= StCapture;
            end
          end
          StCapture: begin
            if (frame_start) begin
              state_q <= StLocked;
            end else if (hit) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= 16'(row_base_q + col_q);
              wr_data_q <= rgb_q;
              if (last_hit) begin
                state_q     <= StLocked;
                done_pend_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q  <= StSeek;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule

// File: tb/tb_vga_capture.sv
// Randomized bench for vga_capture on a shrunken timing geometry. A frame-level reference model
// predicts lock status, the write list (address, data, cycle), frame_done and err per frame.
module tb_vga_capture;

  localparam int HV_ALL = 40, HV_A = 4, HV_B = 4, HV_C = 24;
  localparam int VV_ALL = 20, VV_A = 2, VV_B = 2, VV_C = 12;
  localparam int SCALE = 4, BASE = 100;
  localparam int XS = HV_A + HV_B, YS = VV_A + VV_B;
  localparam int COLS = HV_C / SCALE, ROWS = VV_C / SCALE;
  localparam int XLAST = XS + (COLS - 1) * SCALE, YLAST = YS + (ROWS - 1) * SCALE;
  localparam int SHORT_LEN = 36, EVT_LINE = 10, NFRAMES = 24;
`ifdef VGA_CAPTURE_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, hs = 1'b1, vs = 1'b1, cap_en = 1'b0;
  logic [7:0]  rgb = '0;
  logic        wr_en, frame_done, locked, err;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  vga_capture #(
    .HV_ALL(HV_ALL), .HV_A(HV_A), .HV_B(HV_B), .HV_C(HV_C),
    .VV_ALL(VV_ALL), .VV_A(VV_A), .VV_B(VV_B), .VV_C(VV_C),
    .SCALE(SCALE), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .rgb(rgb), .cap_en(cap_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Output monitor: logs every write, frame_done and err with its cycle.
  int wr_a_q[$], wr_d_q[$], wr_c_q[$], fd_q[$], err_q[$];
  always @(negedge clk) begin
    if (wr_en) begin
      wr_a_q.push_back(int'(wr_addr));
      wr_d_q.push_back(int'(wr_data));
      wr_c_q.push_back(cyc);
    end
    if (frame_done) fd_q.push_back(cyc);
    if (err) err_q.push_back(cyc);
  end

  int pix [VV_ALL][HV_ALL];
  int dcyc[VV_ALL][HV_ALL];

  typedef enum int {MSeek, MArmed, MLocked, MCapture} mstate_t;
  mstate_t ms = MSeek;
  bit cap_cur = 1'b0;

  task automatic check_reset_outputs(input string tag);
    check({tag, " wr_en"}, int'(wr_en), 0);
    check({tag, " wr_addr"}, int'(wr_addr), BASE);
    check({tag, " wr_data"}, int'(wr_data), 0);
    check({tag, " frame_done"}, int'(frame_done), 0);
    check({tag, " locked"}, int'(locked), 0);
    check({tag, " err"}, int'(err), 0);
  endtask

  // Drives one frame; cap_en pulses high mid-frame, then settles to cap_next for the next start.
  task automatic drive_frame(input int f, input bit cap_next, input int short_line,
                             input int rst_line, input bit pattern, input bit exp_mid);
    int len;
    for (int y = 0; y < VV_ALL; y++) begin
      len = (y == short_line) ? SHORT_LEN : HV_ALL;
      for (int x = 0; x < len; x++) begin
        @(negedge clk);
        hs  = (x < HV_A) ? 1'b0 : 1'b1;
        vs  = (y < VV_A) ? 1'b0 : 1'b1;
        rgb = pattern ? 8'(x + y) : 8'($urandom);
        pix[y][x]  = int'(rgb);
        dcyc[y][x] = cyc;
        if (y == 8 && x == 0) cap_en = 1'b1;
        if (y == 13 && x == 0) cap_en = cap_next;
        if (y == 2 && x == 0) check($sformatf("f%0d locked_mid", f), int'(locked), int'(exp_mid));
        if (y == rst_line && x == 0) begin
          rst_n = 1'b0;
          #1;
          check_reset_outputs($sformatf("f%0d midreset", f));
        end
        if (y == rst_line && x == 6) rst_n = 1'b1;
      end
    end
  endtask

  task automatic run_frame(input int f, input bit cap_next, input int short_line,
                           input int rst_line, input bit pattern);
    bit was_cap, viol, exp_mid;
    int cut, y, x, exp_fd;
    int ea[$], ed[$], ec[$];

    // Frame-start decision from the lock history and cap_en at this start.
    case (ms)
      MSeek:   ms = CheckEn ? MArmed : MLocked;
      MArmed:  ms = MLocked;
      MLocked: ms = cap_cur ? MCapture : MLocked;
      default: ms = MLocked;
    endcase
    was_cap = (ms == MCapture);
    exp_mid = (ms == MLocked) || (ms == MCapture);
    viol    = CheckEn && (short_line >= 0) && (ms != MSeek);

    wr_a_q.delete(); wr_d_q.delete(); wr_c_q.delete(); fd_q.delete(); err_q.delete();
    drive_frame(f, cap_next, short_line, rst_line, pattern, exp_mid);
    #2;

    cut = VV_ALL;
    if (viol) cut = short_line + 1;
    if (rst_line >= 0) cut = rst_line;
    if (was_cap) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          y = YS + r * SCALE;
          x = XS + c * SCALE;
          if (y < cut) begin
            ea.push_back(BASE + r * COLS + c);
            ed.push_back(pix[y][x]);
            ec.push_back(dcyc[y][x] + 2);
          end
        end
      end
    end
    check($sformatf("f%0d wr_count", f), wr_a_q.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wr_a_q.size(); i++) begin
      check($sformatf("f%0d wr_addr[%0d]", f, i), wr_a_q[i], ea[i]);
      check($sformatf("f%0d wr_data[%0d]", f, i), wr_d_q[i], ed[i]);
      check($sformatf("f%0d wr_cycle[%0d]", f, i), wr_c_q[i], ec[i]);
    end

    exp_fd = (was_cap && cut == VV_ALL) ? 1 : 0;
    check($sformatf("f%0d frame_done_count", f), fd_q.size(), exp_fd);
    if (exp_fd == 1 && fd_q.size() == 1)
      check($sformatf("f%0d frame_done_cycle", f), fd_q[0], dcyc[YLAST][XLAST] + 3);

    check($sformatf("f%0d err_count", f), err_q.size(), viol ? 1 : 0);
    if (viol && err_q.size() == 1)
      check($sformatf("f%0d err_cycle", f), err_q[0], dcyc[short_line + 1][0] + 2);

    if (viol || rst_line >= 0) ms = MSeek;
    else if (was_cap) ms = MLocked;
    check($sformatf("f%0d locked_end", f), int'(locked),
          int'((ms == MLocked) || (ms == MCapture)));
    cap_cur = cap_next;
  endtask

  initial begin
    bit cap_next;
    int short_line, rst_line;

    // Reset held under random input activity.
    repeat (40) begin
      @(negedge clk);
      hs     = 1'($urandom);
      vs     = 1'($urandom);
      rgb    = 8'($urandom);
      cap_en = 1'($urandom);
    end
    #1;
    check_reset_outputs("reset_held");
    check("reset_held writes", wr_a_q.size(), 0);

    @(negedge clk);
    hs = 1'b1; vs = 1'b1; cap_en = 1'b1; cap_cur = 1'b1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int f = 0; f < NFRAMES; f++) begin
      cap_next = (f < 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (f == 5) cap_next = 1'b0;
      if (f == 8 || f == 11 || f == 12 || f == 16) cap_next = 1'b1;
      short_line = (f == 9 || f == 17) ? EVT_LINE : -1;
      rst_line   = (f == 13) ? EVT_LINE : -1;
      run_frame(f, cap_next, short_line, rst_line, f < 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
